// File: rtl/sdram_mport_pkg.sv
// Shared types and helpers for the multi-port SDRAM front end.
// Slot numbering is 2*channel + direction.
package sdram_mport_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } state_t;

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    function automatic int slot_w(input int n_ch);
        return (2 * n_ch > 2) ? $clog2(2 * n_ch) : 1;
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Combinational round-robin priority encoder.
// The search begins at slot ptr and wraps around.
module sdram_rr_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         valid
);

    logic [W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = W'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/sdram_mport_arbiter.sv
// N-channel burst arbiter in front of a single-port SDRAM controller,
// with optional per-channel ping-pong frame banking on the address MSB.
module sdram_mport_arbiter
    import sdram_mport_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 16,
    parameter int BURST_W     = 10,
    parameter int FRAME_WORDS = 786432,
    parameter int PINGPANG_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_wr_req,
    output logic [NUM_CH-1:0]         ch_wr_ack,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_wr_addr,
    input  logic [NUM_CH*BURST_W-1:0] ch_wr_burst,
    input  logic [NUM_CH*DATA_W-1:0]  ch_din,
    input  logic [NUM_CH-1:0]         ch_rd_req,
    output logic [NUM_CH-1:0]         ch_rd_ack,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_rd_addr,
    input  logic [NUM_CH*BURST_W-1:0] ch_rd_burst,
    output logic [DATA_W-1:0]         ch_dout,
    output logic [NUM_CH-1:0]         ch_rd_bank,
    input  logic                      sdram_init_done,
    output logic                      sdram_wr_req,
    input  logic                      sdram_wr_ack,
    output logic [ADDR_W-1:0]         sdram_wr_addr,
    output logic [BURST_W-1:0]        sdram_wr_burst,
    output logic [DATA_W-1:0]         sdram_din,
    output logic                      sdram_rd_req,
    input  logic                      sdram_rd_ack,
    output logic [ADDR_W-1:0]         sdram_rd_addr,
    output logic [BURST_W-1:0]        sdram_rd_burst,
    input  logic [DATA_W-1:0]         sdram_dout
);

    localparam int NS  = 2 * NUM_CH;
    localparam int SW  = slot_w(NUM_CH);
    localparam int CHW = (SW > 1) ? SW - 1 : 1;
    localparam int CW  = $clog2(FRAME_WORDS + 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NS - 1);

    state_t              state;
    logic [SW-1:0]       ptr_q;
    logic [SW-1:0]       slot_q;
    logic                act_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BURST_W-1:0]  burst_q;
    logic                wr_req_q;
    logic                rd_req_q;

    logic [NS-1:0]       slot_req;
    logic [SW-1:0]       gnt_slot;
    logic                gnt_vld;
    logic [CHW-1:0]      g_ch;
    logic                g_dir;
    logic [ADDR_W-1:0]   g_addr;
    logic [BURST_W-1:0]  g_burst;
    logic [CHW-1:0]      cur_ch;
    logic                cur_dir;
    logic                cur_ack;
    logic [NUM_CH-1:0]   wr_bank;
    logic [NUM_CH-1:0]   rd_bank;

    // Zero-length bursts look idle to the arbiter.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        assign slot_req[2*i] = ch_wr_req[i]
            && (ch_wr_burst[i*BURST_W +: BURST_W] != '0);
        assign slot_req[2*i+1] = ch_rd_req[i]
            && (ch_rd_burst[i*BURST_W +: BURST_W] != '0);
    end

    sdram_rr_arbiter #(
        .N (NS),
        .W (SW)
    ) u_arb (
        .req   (slot_req),
        .ptr   (ptr_q),
        .grant (gnt_slot),
        .valid (gnt_vld)
    );

    assign g_ch    = CHW'(gnt_slot >> 1);
    assign g_dir   = gnt_slot[0];
    assign cur_ch  = CHW'(slot_q >> 1);
    assign cur_dir = slot_q[0];
    assign cur_ack = cur_dir ? sdram_rd_ack : sdram_wr_ack;

    always_comb begin
        g_addr  = ch_wr_addr[g_ch*ADDR_W +: ADDR_W];
        g_burst = ch_wr_burst[g_ch*BURST_W +: BURST_W];
        if (g_dir == DIR_RD) begin
            g_addr  = ch_rd_addr[g_ch*ADDR_W +: ADDR_W];
            g_burst = ch_rd_burst[g_ch*BURST_W +: BURST_W];
        end
        if (PINGPANG_EN != 0) begin
            g_addr[ADDR_W-1] = (g_dir == DIR_RD) ? rd_bank[g_ch]
                                                 : wr_bank[g_ch];
        end
    end

    // ptr_q is the first slot searched: one past the last grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr_q    <= '0;
            slot_q   <= '0;
            act_q    <= 1'b0;
            addr_q   <= '0;
            burst_q  <= '0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (sdram_init_done && gnt_vld) begin
                        slot_q   <= gnt_slot;
                        act_q    <= 1'b1;
                        addr_q   <= g_addr;
                        burst_q  <= g_burst;
                        wr_req_q <= (g_dir == DIR_WR);
                        rd_req_q <= (g_dir == DIR_RD);
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cur_ack) begin
                        wr_req_q <= 1'b0;
                        rd_req_q <= 1'b0;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!cur_ack) state <= ST_DONE;
                end
                ST_DONE: begin
                    act_q <= 1'b0;
                    ptr_q <= (slot_q == LAST_SLOT) ? '0
                                                   : slot_q + 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ch_wr_ack = '0;
        ch_rd_ack = '0;
        if (act_q) begin
            if (cur_dir == DIR_RD) ch_rd_ack[cur_ch] = sdram_rd_ack;
            else                   ch_wr_ack[cur_ch] = sdram_wr_ack;
        end
    end

    assign sdram_din = (act_q && cur_dir == DIR_WR)
                     ? ch_din[cur_ch*DATA_W +: DATA_W] : '0;
    assign ch_dout   = (act_q && cur_dir == DIR_RD) ? sdram_dout : '0;

    assign sdram_wr_req   = wr_req_q;
    assign sdram_rd_req   = rd_req_q;
    assign sdram_wr_addr  = addr_q;
    assign sdram_rd_addr  = addr_q;
    assign sdram_wr_burst = burst_q;
    assign sdram_rd_burst = burst_q;
    assign ch_rd_bank     = rd_bank;

    if (PINGPANG_EN != 0) begin : g_pp
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch_bank
            logic [CW-1:0] cnt;
            logic          wb;
            logic          rb;

            // Read bank freezes while this channel's read is granted.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                    wb  <= 1'b0;
                    rb  <= 1'b0;
                end else begin
                    if (ch_wr_ack[i]) begin
                        if (cnt == CW'(FRAME_WORDS - 1)) begin
                            cnt <= '0;
                            wb  <= ~wb;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    if (!(act_q && cur_dir == DIR_RD
                          && cur_ch == CHW'(i)))
                        rb <= ~wb;
                end
            end

            assign wr_bank[i] = wb;
            assign rd_bank[i] = rb;
        end
    end else begin : g_nopp
        assign wr_bank = '0;
        assign rd_bank = '0;
    end

endmodule

// File: tb/tb_sdram_mport_arbiter.sv
// Randomised scoreboard bench for sdram_mport_arbiter with a
// behavioural SDRAM controller and per-slot master models.
module tb_sdram_mport_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 21;
    localparam int DW  = 16;
    localparam int BW  = 10;
    localparam int FW  = 64;
    localparam int NS  = 2 * NCH;

    typedef struct {
        int            ch;
        logic          dir;
        logic [AW-1:0] addr;
        logic [BW-1:0] burst;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    ch_wr_req;
    logic [NCH-1:0]    ch_wr_ack;
    logic [NCH*AW-1:0] ch_wr_addr;
    logic [NCH*BW-1:0] ch_wr_burst;
    logic [NCH*DW-1:0] ch_din;
    logic [NCH-1:0]    ch_rd_req;
    logic [NCH-1:0]    ch_rd_ack;
    logic [NCH*AW-1:0] ch_rd_addr;
    logic [NCH*BW-1:0] ch_rd_burst;
    logic [DW-1:0]     ch_dout;
    logic [NCH-1:0]    ch_rd_bank;
    logic              sdram_init_done;
    logic              sdram_wr_req;
    logic              sdram_wr_ack;
    logic [AW-1:0]     sdram_wr_addr;
    logic [BW-1:0]     sdram_wr_burst;
    logic [DW-1:0]     sdram_din;
    logic              sdram_rd_req;
    logic              sdram_rd_ack;
    logic [AW-1:0]     sdram_rd_addr;
    logic [BW-1:0]     sdram_rd_burst;
    logic [DW-1:0]     sdram_dout;

    exp_t          exp_q[$];
    exp_t          cur;
    logic          have_cur;
    logic          prev_req;
    int            checks = 0;
    int            errors = 0;
    int            wcnt[NCH];
    int            ptr_m;
    int            rb[NS];
    logic [AW-1:0] ra[NS];

    sdram_mport_arbiter #(
        .NUM_CH      (NCH),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .BURST_W     (BW),
        .FRAME_WORDS (FW),
        .PINGPANG_EN (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ch_wr_req       (ch_wr_req),
        .ch_wr_ack       (ch_wr_ack),
        .ch_wr_addr      (ch_wr_addr),
        .ch_wr_burst     (ch_wr_burst),
        .ch_din          (ch_din),
        .ch_rd_req       (ch_rd_req),
        .ch_rd_ack       (ch_rd_ack),
        .ch_rd_addr      (ch_rd_addr),
        .ch_rd_burst     (ch_rd_burst),
        .ch_dout         (ch_dout),
        .ch_rd_bank      (ch_rd_bank),
        .sdram_init_done (sdram_init_done),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_wr_burst  (sdram_wr_burst),
        .sdram_din       (sdram_din),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_rd_burst  (sdram_rd_burst),
        .sdram_dout      (sdram_dout)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic bank_of(input int c);
        return ((wcnt[c] / FW) % 2) != 0;
    endfunction

    function automatic logic [NCH-1:0] exp_rd_bank();
        logic [NCH-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c] = ~bank_of(c);
        return v;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ch_din = '0;
        forever begin
            @(posedge clk);
            #2;
            ch_din = {$urandom, $urandom};
        end
    end

    // Controller model: acks for exactly the requested burst length.
    initial begin
        int   n;
        logic d;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        sdram_dout   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (sdram_wr_req || sdram_rd_req)) begin
                d = sdram_rd_req;
                n = d ? int'(sdram_rd_burst) : int'(sdram_wr_burst);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                for (int k = 0; k < n; k++) begin
                    if (rst) break;
                    if (d) begin
                        sdram_rd_ack = 1'b1;
                        sdram_dout   = DW'($urandom);
                    end else begin
                        sdram_wr_ack = 1'b1;
                    end
                    @(posedge clk);
                    #1;
                end
                sdram_wr_ack = 1'b0;
                sdram_rd_ack = 1'b0;
                sdram_dout   = '0;
            end
        end
    end

    // Monitor: pops the expected grant on each request rise.
    initial begin
        logic [NCH-1:0] ew;
        logic [NCH-1:0] er;
        logic           rq;
        have_cur = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                have_cur = 1'b0;
                prev_req = 1'b0;
                continue;
            end
            rq = sdram_wr_req | sdram_rd_req;
            if (rq && !prev_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    chk("grant_dir", sdram_rd_req, cur.dir);
                    chk("grant_addr",
                        cur.dir ? sdram_rd_addr : sdram_wr_addr,
                        cur.addr);
                    chk("grant_burst",
                        cur.dir ? sdram_rd_burst : sdram_wr_burst,
                        cur.burst);
                end
            end
            prev_req = rq;
            ew = '0;
            er = '0;
            if (have_cur) begin
                if (cur.dir) er[cur.ch] = sdram_rd_ack;
                else         ew[cur.ch] = sdram_wr_ack;
            end
            chk("ch_wr_ack", ch_wr_ack, ew);
            chk("ch_rd_ack", ch_rd_ack, er);
            if (have_cur && (sdram_wr_ack || sdram_rd_ack)) begin
                chk("addr_held",
                    cur.dir ? sdram_rd_addr : sdram_wr_addr, cur.addr);
                if (cur.dir)
                    chk("rd_data", ch_dout, sdram_dout);
                else
                    chk("wr_data", sdram_din, ch_din[cur.ch*DW +: DW]);
            end
        end
    end

    task automatic run_round(input logic [NS-1:0] act,
                             input bit init_chk);
        exp_t           tq[$];
        exp_t           e;
        logic [NS-1:0]  pend;
        logic [NS-1:0]  seen;
        int             s;
        int             c;
        int             last;
        int             cyc;
        logic           a;
        pend = '0;
        seen = '0;
        last = -1;
        for (int k = 0; k < NS; k++) begin
            s = (ptr_m + k) % NS;
            if (act[s] && rb[s] != 0) begin
                c = s / 2;
                e.ch    = c;
                e.dir   = s[0];
                e.burst = BW'(rb[s]);
                e.addr  = ra[s];
                e.addr[AW-1] = s[0] ? ~bank_of(c) : bank_of(c);
                if (!s[0]) wcnt[c] += rb[s];
                tq.push_back(e);
                pend[s] = 1'b1;
                last = s;
            end
        end
        if (last >= 0) ptr_m = (last + 1) % NS;

        @(negedge clk);
        for (int t = 0; t < NS; t++) begin
            if (act[t]) begin
                c = t / 2;
                if (t % 2 == 0) begin
                    ch_wr_req[c] = 1'b1;
                    ch_wr_addr[c*AW +: AW]  = ra[t];
                    ch_wr_burst[c*BW +: BW] = BW'(rb[t]);
                end else begin
                    ch_rd_req[c] = 1'b1;
                    ch_rd_addr[c*AW +: AW]  = ra[t];
                    ch_rd_burst[c*BW +: BW] = BW'(rb[t]);
                end
            end
        end
        if (init_chk) begin
            repeat (8) begin
                @(negedge clk);
                chk("no_req_before_init",
                    {sdram_wr_req, sdram_rd_req}, 0);
            end
        end
        foreach (tq[i]) exp_q.push_back(tq[i]);
        if (init_chk) begin
            sdram_init_done = 1'b1;
            @(negedge clk);
            chk("req_one_cycle_after_init", sdram_wr_req, 1);
        end

        cyc = 0;
        while (pend != '0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            for (int t = 0; t < NS; t++) begin
                if (pend[t]) begin
                    c = t / 2;
                    a = (t % 2) ? ch_rd_ack[c] : ch_wr_ack[c];
                    if (a) begin
                        seen[t] = 1'b1;
                        if (t % 2 == 0)
                            ch_wr_addr[c*AW +: AW] = AW'($urandom);
                        else
                            ch_rd_addr[c*AW +: AW] = AW'($urandom);
                    end else if (seen[t]) begin
                        pend[t] = 1'b0;
                        if (t % 2 == 0) ch_wr_req[c] = 1'b0;
                        else            ch_rd_req[c] = 1'b0;
                    end
                end
            end
        end
        chk("round_timeout", pend, 0);
        ch_wr_req = '0;
        ch_rd_req = '0;
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("rd_bank", ch_rd_bank, exp_rd_bank());
    endtask

    task automatic set_one(input int s, input int b);
        rb[s] = b;
        ra[s] = AW'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   cnt;
        rst = 1'b1;
        sdram_init_done = 1'b0;
        ch_wr_req = '0;
        ch_rd_req = '0;
        ch_wr_addr = '0;
        ch_rd_addr = '0;
        ch_wr_burst = '0;
        ch_rd_burst = '0;
        ptr_m = 0;
        for (int c = 0; c < NCH; c++) wcnt[c] = 0;
        for (int s = 0; s < NS; s++) set_one(s, 0);

        repeat (3) @(negedge clk);
        chk("rst_reqs", {sdram_wr_req, sdram_rd_req}, 0);
        chk("rst_addr", sdram_wr_addr, 0);
        chk("rst_burst", sdram_rd_burst, 0);
        chk("rst_acks", {ch_wr_ack, ch_rd_ack}, 0);
        chk("rst_rd_bank", ch_rd_bank, 0);
        chk("rst_din", sdram_din, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // ch0 fills exactly one frame in 8 bursts of 8.
        for (int r = 0; r < 8; r++) begin
            set_one(0, 8);
            run_round(8'h01, r == 0);
        end
        set_one(0, 4);
        set_one(1, 4);
        run_round(8'h03, 0);

        for (int c = 0; c < NCH; c++) set_one(2 * c, 8);
        run_round(8'h55, 0);

        set_one(3, 6);
        set_one(4, 7);
        run_round(8'h18, 0);

        set_one(4, 0);
        set_one(2, 5);
        run_round(8'h14, 0);

        for (int r = 0; r < 40; r++) begin
            for (int s = 0; s < NS; s++)
                set_one(s, $urandom_range(0, 10));
            run_round(NS'($urandom), 0);
        end

        // Reset during the 4th word of a 16-word write.
        set_one(0, 16);
        e.ch = 0;
        e.dir = 1'b0;
        e.burst = BW'(16);
        e.addr = ra[0];
        e.addr[AW-1] = bank_of(0);
        for (int k = 0; k < NS; k++) begin
            if ((ptr_m + k) % NS == 0) break;
        end
        @(negedge clk);
        exp_q.push_back(e);
        ch_wr_req[0] = 1'b1;
        ch_wr_addr[0 +: AW] = ra[0];
        ch_wr_burst[0 +: BW] = BW'(16);
        cnt = 0;
        for (int cyc = 0; cyc < 200 && cnt < 4; cyc++) begin
            @(negedge clk);
            if (ch_wr_ack[0]) cnt++;
        end
        chk("reset_burst_reached", cnt, 4);
        rst = 1'b1;
        #1;
        chk("midrst_reqs", {sdram_wr_req, sdram_rd_req}, 0);
        chk("midrst_addr", sdram_wr_addr, 0);
        chk("midrst_burst", sdram_wr_burst, 0);
        chk("midrst_din", sdram_din, 0);
        chk("midrst_acks", {ch_wr_ack, ch_rd_ack}, 0);
        chk("midrst_dout", ch_dout, 0);
        chk("midrst_rd_bank", ch_rd_bank, 0);
        ch_wr_req = '0;
        for (int c = 0; c < NCH; c++) wcnt[c] = 0;
        ptr_m = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int s = 0; s < NS; s++)
            set_one(s, $urandom_range(1, 10));
        run_round(8'hFF, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
